lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Load/store unit between the EX/MEM pipeline register and the byte-array data memory; the memory exposes a word-only interface.
- Converts LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses:
  - Sub-word stores use read-modify-write.
  - Loads are sign- or zero-extended.
- Drives a stall back to the pipeline while an access is in flight.

Parameters:
- MEM_BYTES, 32, data memory size in bytes; used only by the range check.
- ADDR_W, 32, width of the request and memory addresses.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req_i  in  1  request valid from the EX/MEM stage.
- we_i  in  1  1 = store, 0 = load.
- funct3_i  in  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  32  store data; the low bytes are used for sub-word stores.
- stall_o  out  1  high while the unit is busy; the pipeline holds its request.
- rdata_o  out  32  extended load result.
- rvalid_o  out  1  one-cycle pulse; rdata_o is valid.
- err_o  out  1  one-cycle pulse for a faulting request.
- mem_adr_o  out  ADDR_W  word-aligned address to memory (addr & ~3).
- mem_data_o  out  32  write word to memory.
- mem_wr_o  out  1  memory write enable.
- mem_re_o  out  1  memory read enable.
- mem_data_i  in  32  read word from memory, little-endian, combinational.

Behaviour:
- Reset: asynchronous, active-low.
  - State goes to IDLE; every output goes to 0.
  - An in-flight RMW is abandoned and no write is issued; mem_wr_o drops immediately.
- FSM states: IDLE, LD, RMW_RD, WR.
- Request acceptance:
  - A request is accepted on a rising edge with req_i=1 while in IDLE.
  - addr_i, funct3_i, we_i and wdata_i are registered on acceptance.
  - req_i while stall_o=1 is ignored.
- Faults: misaligned halfword (addr[0]=1), misaligned word (addr[1:0]!=0), or funct3 011/110/111.
  - No state change and no memory access.
  - err_o=1 for the next cycle.
- Load: IDLE->LD.
  - In LD: mem_re_o=1 and stall_o=1.
  - At the end of LD, the selected byte/half is extended and registered.
  - Then LD->IDLE, with rvalid_o=1 and rdata_o valid for one cycle.
  - Load-to-use latency is 2 cycles from acceptance.
- Store SW: IDLE->WR.
  - In WR: mem_wr_o=1 and mem_data_o=wdata.
  - Then WR->IDLE.
- Store SB/SH: IDLE->RMW_RD->WR.
  - In RMW_RD: mem_re_o=1; mem_data_i is captured into the merge register.
  - In WR: the merged word is written.
  - Byte lane: addr[1:0]*8; halfword lane: addr[1]*16.
- stall_o is high in LD, RMW_RD and WR; low in IDLE.
- rdata_o holds its last value between pulses.
- Extension rules: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- mem_re_o and mem_wr_o are never high in the same cycle.
- mem_adr_o is stable for the whole access.
- A request may be accepted in the same cycle the FSM returns to IDLE (back-to-back), so a new access starts the cycle after rvalid_o or after WR.

Optional Feature:
- Macro: LSU_RANGE_CHK_EN.
- Defined: a request with addr_i+size-1 >= MEM_BYTES is treated as a fault.
  - err_o pulses and no memory access is made.
  - The check is evaluated alongside alignment, in the same cycle.
- Undefined: no range check; the address passes through unchanged.
  - Only misalignment and illegal funct3 fault.

Test Plan:
- Reset check: reset mid-RMW (assert rst_i low during RMW_RD) -> mem_wr_o=0 immediately; state IDLE; all outputs 0; word at that address unchanged.
- SW 0xDEADBEEF @0x04, then LW @0x04 -> one mem_wr_o pulse with mem_adr_o=0x04; LW gives rvalid_o 2 cycles after acceptance with rdata_o=0xDEADBEEF.
- SB 0x80 @0x05 after the previous step:
  - RMW_RD then WR; memory word = 0xDEAD80EF.
  - LB @0x05 -> 0xFFFFFF80; LBU @0x05 -> 0x00000080.
- SH 0x1234 @0x06 -> word 0x123480EF; LH @0x06 -> 0x00001234; stall_o high exactly 2 cycles.
- LW @0x02 and LH @0x03 -> err_o pulses; no mem_re_o/mem_wr_o; stall_o stays 0.
- With LSU_RANGE_CHK_EN and MEM_BYTES=32: LW @0x1C -> ok; LW @0x20 -> err_o.
- Without LSU_RANGE_CHK_EN: LW @0x20 -> memory access at mem_adr_o=0x20.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store unit between EX/MEM and a word-only data memory: sub-word stores use read-modify-write, loads are extended.
// Optional macro LSU_RANGE_CHK_EN adds a fault for accesses that run past MEM_BYTES.
module lsu_mem_port #(
    parameter int MEM_BYTES = 32,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic [31:0]       rdata_o,
    output logic              rvalid_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic [31:0]       mem_data_o,
    output logic              mem_wr_o,
    output logic              mem_re_o,
    input  logic [31:0]       mem_data_i,
    output logic [1:0]        dbg_state_o
);

    // Handshake: a request is taken on a rising edge where req_i=1 and stall_o=0;
    // the pipeline keeps req_i and its operands steady while stall_o is high.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LD     = 2'd1,
        S_RMW_RD = 2'd2,
        S_WR     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] adr_q;
    logic [1:0]        lane_q;
    logic [2:0]        f3_q;
    logic [31:0]       word_q;
    logic [31:0]       rdata_q;
    logic              rvalid_q;
    logic              err_q;

    logic              accept;
    logic              illegal_f3;
    logic              misalign;
    logic              range_err;
    logic              fault;
    logic [31:0]       merged;
    logic [31:0]       ld_val;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    if (MEM_BYTES < 4) begin : g_bad_mem_bytes
        $error("lsu_mem_port: MEM_BYTES must cover at least one word");
    end

    assign accept     = (state_q == S_IDLE) && req_i;
    assign illegal_f3 = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
    assign misalign   = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                        ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

`ifdef LSU_RANGE_CHK_EN
    logic [ADDR_W:0] last_byte;
    logic [ADDR_W:0] size_m1;

    always_comb begin
        size_m1 = '0;
        case (funct3_i[1:0])
            2'b01:   size_m1 = (ADDR_W+1)'(1);
            2'b10:   size_m1 = (ADDR_W+1)'(3);
            default: size_m1 = '0;
        endcase
    end

    // One extra bit so an address near the top of the space cannot wrap into range.
    assign last_byte = {1'b0, addr_i} + size_m1;
    assign range_err = last_byte >= (ADDR_W+1)'(MEM_BYTES);
`else
    assign range_err = 1'b0;
`endif

    assign fault = illegal_f3 || misalign || range_err;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && !fault) begin
                    if (!we_i)                      state_d = S_LD;
                    else if (funct3_i[1:0] == 2'b10) state_d = S_WR;
                    else                            state_d = S_RMW_RD;
                end
            end
            S_LD:     state_d = S_IDLE;
            S_RMW_RD: state_d = S_WR;
            S_WR:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // word_q holds the store data on acceptance; the sub-word lane is spliced into the read word.
    always_comb begin
        merged = mem_data_i;
        if (f3_q[1:0] == 2'b00) begin
            merged[{lane_q, 3'b000} +: 8] = word_q[7:0];
        end else if (lane_q[1]) begin
            merged[31:16] = word_q[15:0];
        end else begin
            merged[15:0] = word_q[15:0];
        end
    end

    assign ld_byte = mem_data_i[{lane_q, 3'b000} +: 8];
    assign ld_half = lane_q[1] ? mem_data_i[31:16] : mem_data_i[15:0];

    always_comb begin
        ld_val = mem_data_i;
        case (f3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'h0, ld_byte};
            3'b101:  ld_val = {16'h0, ld_half};
            default: ld_val = mem_data_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            adr_q    <= '0;
            lane_q   <= '0;
            f3_q     <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            err_q    <= accept && fault;
            rvalid_q <= (state_q == S_LD);
            if (accept && !fault) begin
                adr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
                lane_q <= addr_i[1:0];
                f3_q   <= funct3_i;
                word_q <= wdata_i;
            end
            if (state_q == S_LD) begin
                rdata_q <= ld_val;
            end
            if (state_q == S_RMW_RD) begin
                word_q <= merged;
            end
        end
    end

    assign stall_o     = (state_q != S_IDLE);
    assign mem_re_o    = (state_q == S_LD) || (state_q == S_RMW_RD);
    assign mem_wr_o    = (state_q == S_WR);
    assign mem_adr_o   = adr_q;
    assign mem_data_o  = word_q;
    assign rdata_o     = rdata_q;
    assign rvalid_o    = rvalid_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port against a small word-array memory model.
module tb_lsu_mem_port;

  logic        clk;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        err_o;
  logic [31:0] mem_adr_o;
  logic [31:0] mem_data_o;
  logic        mem_wr_o;
  logic        mem_re_o;
  logic [31:0] mem_data_i;
  logic [1:0]  dbg_state_o;

  int total = 0;
  int bad   = 0;

  // memory model: 16 words, preload port for the bench
  logic [31:0] mem [0:15];
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [31:0] pl_val;

  lsu_mem_port #(.MEM_BYTES(32), .ADDR_W(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .funct3_i    (funct3_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .stall_o     (stall_o),
    .rdata_o     (rdata_o),
    .rvalid_o    (rvalid_o),
    .err_o       (err_o),
    .mem_adr_o   (mem_adr_o),
    .mem_data_o  (mem_data_o),
    .mem_wr_o    (mem_wr_o),
    .mem_re_o    (mem_re_o),
    .mem_data_i  (mem_data_i),
    .dbg_state_o (dbg_state_o)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_data_i = mem[mem_adr_o[5:2]];

  always @(posedge clk) begin
    if (mem_wr_o) mem[mem_adr_o[5:2]] <= mem_data_o;
    else if (pl_en) mem[pl_idx] <= pl_val;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  // drive one request for a single edge; returns at the negedge after acceptance
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    req_i    = 1'b1;
    we_i     = we;
    funct3_i = f3;
    addr_i   = addr;
    wdata_i  = wd;
    @(negedge clk);
    req_i    = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp);
    issue(1'b0, f3, addr, 32'h0);
    chk({tag, "_re"}, mem_re_o, 1'b1);
    chk({tag, "_wr"}, mem_wr_o, 1'b0);
    chk({tag, "_stall"}, stall_o, 1'b1);
    chk({tag, "_adr"}, mem_adr_o, addr & 32'hFFFF_FFFC);
    @(negedge clk);
    chk({tag, "_rvalid"}, rvalid_o, 1'b1);
    chk({tag, "_rdata"}, rdata_o, exp);
    chk({tag, "_stall_lo"}, stall_o, 1'b0);
  endtask

  task automatic fault_chk(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr);
    issue(we, f3, addr, 32'hA5A5_A5A5);
    chk({tag, "_err"}, err_o, 1'b1);
    chk({tag, "_stall"}, stall_o, 1'b0);
    chk({tag, "_re"}, mem_re_o, 1'b0);
    chk({tag, "_wr"}, mem_wr_o, 1'b0);
    @(negedge clk);
    chk({tag, "_err_lo"}, err_o, 1'b0);
    chk({tag, "_state"}, dbg_state_o, 2'd0);
  endtask

  initial begin
    req_i = 1'b0; we_i = 1'b0; funct3_i = 3'b0; addr_i = '0; wdata_i = '0;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // reset state
    rst_i = 1'b1;
    #1 rst_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_rvalid", rvalid_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_wr", mem_wr_o, 1'b0);
    chk("rst_re", mem_re_o, 1'b0);
    chk("rst_adr", mem_adr_o, 32'h0);
    chk("rst_state", dbg_state_o, 2'd0);
    rst_i = 1'b1;
    @(negedge clk);

    // SW 0xDEADBEEF @0x04
    issue(1'b1, 3'b010, 32'h04, 32'hDEADBEEF);
    chk("sw_wr", mem_wr_o, 1'b1);
    chk("sw_re", mem_re_o, 1'b0);
    chk("sw_adr", mem_adr_o, 32'h04);
    chk("sw_data", mem_data_o, 32'hDEADBEEF);
    chk("sw_stall", stall_o, 1'b1);
    @(negedge clk);
    chk("sw_wr_lo", mem_wr_o, 1'b0);
    chk("sw_stall_lo", stall_o, 1'b0);
    chk("sw_mem", mem[1], 32'hDEADBEEF);

    load_chk("lw4", 3'b010, 32'h04, 32'hDEADBEEF);
    @(negedge clk);
    chk("lw4_rvalid_lo", rvalid_o, 1'b0);
    chk("lw4_rdata_hold", rdata_o, 32'hDEADBEEF);

    // SB 0x80 @0x05; upper store bytes must not leak in
    issue(1'b1, 3'b000, 32'h05, 32'hAAAAAA80);
    chk("sb_rmw_state", dbg_state_o, 2'd2);
    chk("sb_rmw_re", mem_re_o, 1'b1);
    chk("sb_rmw_wr", mem_wr_o, 1'b0);
    chk("sb_adr", mem_adr_o, 32'h04);
    @(negedge clk);
    chk("sb_wr", mem_wr_o, 1'b1);
    chk("sb_wr_re", mem_re_o, 1'b0);
    chk("sb_data", mem_data_o, 32'hDEAD80EF);
    @(negedge clk);
    chk("sb_mem", mem[1], 32'hDEAD80EF);
    chk("sb_stall_lo", stall_o, 1'b0);

    load_chk("lb5", 3'b000, 32'h05, 32'hFFFFFF80);
    load_chk("lbu5", 3'b100, 32'h05, 32'h00000080);

    // SH 0x1234 @0x06: stall high for exactly two cycles
    issue(1'b1, 3'b001, 32'h06, 32'h55551234);
    chk("sh_stall1", stall_o, 1'b1);
    @(negedge clk);
    chk("sh_stall2", stall_o, 1'b1);
    chk("sh_data", mem_data_o, 32'h123480EF);
    @(negedge clk);
    chk("sh_stall3", stall_o, 1'b0);
    chk("sh_mem", mem[1], 32'h123480EF);

    load_chk("lh6", 3'b001, 32'h06, 32'h00001234);
    load_chk("lh4", 3'b001, 32'h04, 32'hFFFF80EF);
    load_chk("lhu4", 3'b101, 32'h04, 32'h000080EF);
    load_chk("lb7", 3'b000, 32'h07, 32'h00000012);

    // faults
    fault_chk("lw2", 1'b0, 3'b010, 32'h02);
    fault_chk("lh3", 1'b0, 3'b001, 32'h03);
    fault_chk("sh5", 1'b1, 3'b001, 32'h05);
    fault_chk("f3_011", 1'b0, 3'b011, 32'h00);
    fault_chk("f3_111", 1'b1, 3'b111, 32'h08);
    chk("fault_mem_kept", mem[1], 32'h123480EF);

    // back-to-back: SW accepted in the cycle rvalid_o is high
    issue(1'b0, 3'b010, 32'h04, 32'h0);
    chk("b2b_ld_re", mem_re_o, 1'b1);
    @(negedge clk);
    chk("b2b_rvalid", rvalid_o, 1'b1);
    chk("b2b_rdata", rdata_o, 32'h123480EF);
    issue(1'b1, 3'b010, 32'h0C, 32'h01020304);
    chk("b2b_wr", mem_wr_o, 1'b1);
    chk("b2b_adr", mem_adr_o, 32'h0C);
    @(negedge clk);
    chk("b2b_mem", mem[3], 32'h01020304);

    // reset in the middle of an RMW: no write lands
    preload(4'd2, 32'h11223344);
    issue(1'b1, 3'b000, 32'h09, 32'h00000099);
    chk("rrst_re", mem_re_o, 1'b1);
    #2 rst_i = 1'b0;
    #1;
    chk("rrst_wr", mem_wr_o, 1'b0);
    chk("rrst_re_lo", mem_re_o, 1'b0);
    chk("rrst_stall", stall_o, 1'b0);
    chk("rrst_state", dbg_state_o, 2'd0);
    chk("rrst_rdata", rdata_o, 32'h0);
    chk("rrst_adr", mem_adr_o, 32'h0);
    chk("rrst_wdata", mem_data_o, 32'h0);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk("rrst_mem", mem[2], 32'h11223344);
    chk("rrst_wr_after", mem_wr_o, 1'b0);

    // range behaviour at MEM_BYTES=32
    preload(4'd7, 32'h0BADF00D);
    preload(4'd8, 32'hCAFEF00D);
    load_chk("lw1c", 3'b010, 32'h1C, 32'h0BADF00D);
`ifdef LSU_RANGE_CHK_EN
    fault_chk("lw20_range", 1'b0, 3'b010, 32'h20);
    fault_chk("lh1f_range", 1'b0, 3'b101, 32'h1F);
`else
    load_chk("lw20", 3'b010, 32'h20, 32'hCAFEF00D);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
